// File: rtl/seq_div.sv
// seq_div: 32-bit signed restoring divider, one quotient bit per clock, divide-by-zero flag.
module seq_div (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  input  logic        ctrl_DIV,
  output logic [31:0] data_result,
  output logic        data_exception,
  output logic        data_resultRDY,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, nxt;
  logic [31:0] rem, quo, dvs, a_mag, b_mag;
  logic [32:0] sh, diff;
  logic [5:0] cnt;
  logic neg, dz, start, step;
  always_comb begin
    nxt = state;
    start = 1'b0;
    step = 1'b0;
    a_mag = data_operandA[31] ? -data_operandA : data_operandA;
    b_mag = data_operandB[31] ? -data_operandB : data_operandB;
    sh = {rem, quo[31]};
    diff = sh - {1'b0, dvs};
    if (state == RUN) begin
      nxt = (cnt == 6'd32) ? DONE : RUN;
      step = cnt != 6'd32;
    end else begin
      nxt = ctrl_DIV ? RUN : IDLE;
      start = ctrl_DIV;
    end
  end
  assign busy = state == RUN;
  // quo starts as |A| and is shifted out as quotient bits shift in
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      neg <= 1'b0;
      dz <= 1'b0;
      cnt <= '0;
      data_result <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
    end else begin
      state <= nxt;
      data_resultRDY <= nxt == DONE;
      if (start) begin
        rem <= '0;
        quo <= a_mag;
        dvs <= b_mag;
        neg <= data_operandA[31] ^ data_operandB[31];
        dz <= data_operandB == '0;
        cnt <= '0;
      end else if (step) begin
        rem <= diff[32] ? sh[31:0] : diff[31:0];
        quo <= {quo[30:0], ~diff[32]};
        cnt <= cnt + 6'd1;
      end
      if (nxt == DONE) begin
        data_result <= dz ? '0 : neg ? -quo : quo;
        data_exception <= dz;
      end
    end
  end
endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: directed and random checks of seq_div against a signed-arithmetic reference.
module tb_seq_div;
  logic clock = 1'b0, reset = 1'b1, ctrl_DIV = 1'b0;
  logic [31:0] data_operandA = '0, data_operandB = '0;
  logic [31:0] data_result;
  logic data_exception, data_resultRDY, busy;
  int tests = 0, fails = 0;

  seq_div dut (
    .clock(clock), .reset(reset), .data_operandA(data_operandA), .data_operandB(data_operandB),
    .ctrl_DIV(ctrl_DIV), .data_result(data_result), .data_exception(data_exception),
    .data_resultRDY(data_resultRDY), .busy(busy)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] model_q(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) return 32'h0;
    q = sa / sb;
    return q[31:0];
  endfunction

  // drive a start request for one edge, then scramble operands
  task automatic launch(input logic [31:0] a, input logic [31:0] b);
    data_operandA = a;
    data_operandB = b;
    ctrl_DIV = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic wait_rdy(output int k);
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic test_reset;
    #2;
    tests++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'h0) begin
      fails++;
      $display("FAIL reset_outputs got %h expected 0", {data_result, data_exception, data_resultRDY, busy});
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_directed;
    logic [31:0] va[8] = '{32'd100, 32'hFFFFFF9C, 32'd100, 32'hFFFFFF9C, 32'd5, 32'h80000000, 32'h80000000, 32'h7FFFFFFF};
    logic [31:0] vb[8] = '{32'd7, 32'd7, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF, 32'd2, 32'd1};
    logic [31:0] ve[8] = '{32'h0000000E, 32'hFFFFFFF2, 32'hFFFFFFF2, 32'h0000000E, 32'h0, 32'h80000000, 32'hC0000000, 32'h7FFFFFFF};
    int k;
    for (int i = 0; i < 8; i++) begin
      launch(va[i], vb[i]);
      tests++;
      if (busy !== 1'b1) begin
        fails++;
        $display("FAIL dir%0d_busy got %b expected 1", i, busy);
      end
      wait_rdy(k);
      tests++;
      if (k !== 33) begin
        fails++;
        $display("FAIL dir%0d_latency got %0d expected 33", i, k);
      end
      tests++;
      if (data_result !== ve[i] || data_exception !== (i == 4)) begin
        fails++;
        $display("FAIL dir%0d_result got %h/%b expected %h/%b", i, data_result, data_exception, ve[i], i == 4);
      end
      repeat (3) @(posedge clock);
      #1;
      tests++;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== ve[i]) begin
        fails++;
        $display("FAIL dir%0d_hold got rdy=%b busy=%b res=%h expected 0/0/%h", i, data_resultRDY, busy, data_result, ve[i]);
      end
    end
  endtask

  task automatic test_random;
    logic [31:0] a, b;
    int k;
    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0: b = 32'h0;
        1: b = $urandom_range(1, 20);
        2: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      launch(a, b);
      wait_rdy(k);
      tests++;
      if (k !== 33 || data_result !== model_q(a, b) || data_exception !== (b == 0)) begin
        fails++;
        $display("FAIL rand%0d %h/%h got lat=%0d res=%h exc=%b expected 33 %h %b",
                 i, a, b, k, data_result, data_exception, model_q(a, b), b == 0);
      end
    end
  endtask

  task automatic test_abort;
    int k;
    bit seen = 0;
    launch(32'd1000, 32'd10);
    repeat (9) @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    tests++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'h0) begin
      fails++;
      $display("FAIL abort_async got %h expected 0", {data_result, data_exception, data_resultRDY, busy});
    end
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY || busy) seen = 1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++;
      $display("FAIL abort_no_rdy got activity=%b expected 0", seen);
    end
    launch(32'd9, 32'd3);
    wait_rdy(k);
    tests++;
    if (k !== 33 || data_result !== 32'h3 || data_exception !== 1'b0) begin
      fails++;
      $display("FAIL abort_restart got lat=%0d res=%h exc=%b expected 33 00000003 0", k, data_result, data_exception);
    end
  endtask

  task automatic test_back_to_back;
    int k;
    launch(32'd50, 32'd5);
    repeat (4) @(posedge clock);
    #1;
    data_operandA = 32'd7;
    data_operandB = 32'd7;
    ctrl_DIV = 1'b1;
    @(posedge clock);
    #1;
    ctrl_DIV = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (data_resultRDY) break;
      @(posedge clock);
      #1;
    end
    tests++;
    if (data_resultRDY !== 1'b1 || data_result !== 32'hA) begin
      fails++;
      $display("FAIL ignore_restart got rdy=%b res=%h expected 1 0000000a", data_resultRDY, data_result);
    end
    launch(32'd21, 32'd4);
    tests++;
    if (data_resultRDY !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL b2b_start got rdy=%b busy=%b expected 0 1", data_resultRDY, busy);
    end
    wait_rdy(k);
    tests++;
    if (k !== 33 || data_result !== 32'h5) begin
      fails++;
      $display("FAIL b2b_result got lat=%0d res=%h expected 33 00000005", k, data_result);
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_abort;
    test_back_to_back;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
